serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand set presented.
REQ-005 SHALL have port in_ready  output  1  controller can accept operands.
REQ-006 SHALL have port a  input  WIDTH  first operand.
REQ-007 SHALL have port b  input  WIDTH  second operand.
REQ-008 SHALL have port c_in  input  1  carry input for the addition.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port sum  output  WIDTH  result bits.
REQ-012 SHALL have port c_out  output  1  final carry out.
REQ-013 SHALL have port busy  output  1  high while in RUN.

Function
REQ-014 SHALL implement FSM with states IDLE, RUN, DONE, using one 1-bit full-adder cell reused every cycle, LSB first.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, latch a, b and c_in into internal shift registers and carry flop, clear bit counter, go to RUN.
REQ-016 RUN: each cycle add bit[counter] of the latched a, b and the carry flop; shift the sum bit into the result register at MSB-aligned position; update the carry flop; increment counter.
REQ-017 RUN SHALL last exactly WIDTH cycles, then go to DONE; acceptance at edge k gives out_valid=1 after edge k+WIDTH.
REQ-018 DONE: out_valid=1, sum and c_out stable; on out_ready go to IDLE at the same edge; while out_ready=0, hold all outputs unchanged indefinitely.
REQ-019 Result SHALL equal {c_out,sum} = a + b + c_in (WIDTH+1-bit exact sum) using values latched at acceptance.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid and operand changes there are ignored and do not affect the result.
REQ-021 sum and c_out SHALL be 0 in IDLE before the first result and SHALL retain the last result in IDLE afterwards; they are only qualified by out_valid.
REQ-022 busy SHALL be 1 exactly in RUN.
REQ-023 Counter SHALL be ceil(log2(WIDTH+1)) bits wide; no wrap-around occurs within a transaction.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, counter=0, carry flop=0, sum=0, c_out=0, out_valid=0, busy=0, in_ready=1 on the following cycle.
REQ-025 Reset in RUN or DONE SHALL abort the transaction with no result output; rst has priority over all handshakes in the same cycle.

Configuration
REQ-026 Macro SERIAL_ADD_SUB_EN SHALL, when defined, add port sub  input  1  latched with operands at acceptance.
REQ-027 With SERIAL_ADD_SUB_EN and sub=1: each cycle use the inverted b bit, preset carry flop to 1 and ignore c_in, giving {c_out,sum} = a + ~b + 1 (c_out=1 means no borrow); sub=0 behaves as REQ-019.
REQ-028 Without SERIAL_ADD_SUB_EN: no sub port, addition only, no inversion logic present.

Verification
REQ-029 WIDTH=8, a=0xFF, b=0x01, c_in=0, out_ready=1 -> out_valid rises 8 cycles after acceptance, sum=0x00, c_out=1, back to IDLE next edge.
REQ-030 WIDTH=8, a=0x00, b=0x00, c_in=1 -> sum=0x01, c_out=0; a=0x5A, b=0xA5, c_in=0 -> sum=0xFF, c_out=0.
REQ-031 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b -> in_ready=0 throughout, sum/c_out unchanged, single acceptance only after out_ready pulse.
REQ-032 Assert rst 3 cycles into RUN -> next cycle IDLE, out_valid=0, busy=0, sum=0, c_out=0; new transaction then completes correctly.
REQ-033 With SERIAL_ADD_SUB_EN, sub=1, a=0x05, b=0x07, c_in=1 -> sum=0xFE, c_out=0; a=0x07, b=0x05 -> sum=0x02, c_out=1.
REQ-034 Back-to-back: in_valid held high with out_ready=1 -> one acceptance every WIDTH+2 cycles, results in order.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused LSB first over WIDTH cycles.
// Optional macro SERIAL_ADD_SUB_EN adds a `sub` port for a + ~b + 1 subtraction.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_bbit;
    logic             w_sbit;
    logic             w_cbit;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
    logic r_sub;
    assign w_bbit = r_b[0] ^ r_sub;
`else
    assign w_bbit = r_b[0];
`endif

    assign w_sbit = r_a[0] ^ w_bbit ^ r_carry;
    assign w_cbit = (r_a[0] & w_bbit) | (r_carry & (r_a[0] ^ w_bbit));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_RUN:   busy      = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Operands shift right so bit 0 is always the current bit; the sum shifts in at the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_cnt <= '0;
`ifdef SERIAL_ADD_SUB_EN
            r_sub   <= sub;
            r_carry <= sub ? 1'b1 : c_in;
`else
            r_carry <= c_in;
`endif
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= {w_sbit, r_res[WIDTH-1:1]};
            r_carry <= w_cbit;
            r_cnt   <= r_cnt + CW'(1);
            // Outputs change only when the result is complete, so they hold through DONE and IDLE.
            if (w_last) begin
                r_sum  <= {w_sbit, r_res[WIDTH-1:1]};
                r_cout <= w_cbit;
            end
        end
    end

    assign sum   = r_sum;
    assign c_out = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH=8); sub tests run only with SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set for a single IDLE cycle; returns just after the acceptance edge.
    task automatic start(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc);
        a = ta; b = tb_; c_in = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk_cnt++;
        if ({in_ready, out_valid, busy} !== 3'b100)
            $display("FAIL reset_ctrl: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
        else pass_cnt++;
        chk_cnt++;
        if ({c_out, sum} !== 9'h000)
            $display("FAIL reset_result: got %h want 000", {c_out, sum});
        else pass_cnt++;
    endtask

    task automatic test_add_basic();
        int n;
        out_ready = 1'b1;
        start(8'hFF, 8'h01, 1'b0);
        chk_cnt++;
        if ({busy, in_ready} !== 2'b10)
            $display("FAIL run_flags: got busy/rdy=%b want 10", {busy, in_ready});
        else pass_cnt++;
        wait_done(n);
        chk_cnt++;
        if (n !== WIDTH) $display("FAIL latency: got %0d want %0d", n, WIDTH);
        else pass_cnt++;
        chk_cnt++;
        if ({c_out, sum} !== 9'h100) $display("FAIL ff_plus_01: got %h want 100", {c_out, sum});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({in_ready, out_valid, busy} !== 3'b100)
            $display("FAIL back_to_idle: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
        else pass_cnt++;
    endtask

    task automatic test_vectors();
        logic [WIDTH-1:0] va [4] = '{8'h00, 8'h5A, 8'hFF, 8'h3C};
        logic [WIDTH-1:0] vb [4] = '{8'h00, 8'hA5, 8'hFF, 8'h0F};
        logic             vc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [WIDTH:0]   ve [4] = '{9'h001, 9'h0FF, 9'h1FF, 9'h04C};
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start(va[i], vb[i], vc[i]);
            wait_done(n);
            chk_cnt++;
            if ({c_out, sum} !== ve[i])
                $display("FAIL vector%0d: got %h want %h", i, {c_out, sum}, ve[i]);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_hold();
        int n;
        out_ready = 1'b0;
        start(8'h12, 8'h34, 1'b1);
        wait_done(n);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 8'hC3 ^ 8'(i);
            b = 8'h1E + 8'(i);
            c_in = ~i[0];
            tick();
            chk_cnt++;
            if ({in_ready, out_valid, c_out, sum} !== {2'b01, 9'h047})
                $display("FAIL hold%0d: got rdy/vld=%b res=%h want 01 047", i,
                         {in_ready, out_valid}, {c_out, sum});
            else pass_cnt++;
        end
        a = 8'h10; b = 8'h20; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk_cnt++;
        if ({in_ready, out_valid, c_out, sum} !== {2'b10, 9'h047})
            $display("FAIL hold_release: got rdy/vld=%b res=%h want 10 047",
                     {in_ready, out_valid}, {c_out, sum});
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL hold_accept: got busy=%b want 1", busy);
        else pass_cnt++;
        wait_done(n);
        chk_cnt++;
        if ({c_out, sum} !== 9'h030) $display("FAIL hold_next: got %h want 030", {c_out, sum});
        else pass_cnt++;
        tick(); tick();
        chk_cnt++;
        if ({in_ready, busy} !== 2'b10)
            $display("FAIL single_accept: got rdy/busy=%b want 10", {in_ready, busy});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n;
        out_ready = 1'b1;
        start(8'hAA, 8'h55, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cnt++;
        if ({in_ready, out_valid, busy, c_out, sum} !== {3'b100, 9'h000})
            $display("FAIL reset_mid: got rdy/vld/busy=%b res=%h want 100 000",
                     {in_ready, out_valid, busy}, {c_out, sum});
        else pass_cnt++;
        start(8'h0F, 8'h01, 1'b0);
        wait_done(n);
        chk_cnt++;
        if (n !== WIDTH || {c_out, sum} !== 9'h010)
            $display("FAIL after_reset: got lat=%0d res=%h want %0d 010", n, {c_out, sum}, WIDTH);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] va [3] = '{8'h01, 8'h80, 8'h7F};
        logic [WIDTH-1:0] vb [3] = '{8'h02, 8'h80, 8'h00};
        logic             vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [WIDTH:0]   ve [3] = '{9'h003, 9'h100, 9'h080};
        int acc_cyc [3];
        int nacc = 0;
        int nres = 0;
        logic prev_busy = 1'b0;
        out_ready = 1'b1;
        a = va[0]; b = vb[0]; c_in = vc[0]; in_valid = 1'b1;
        for (int cyc = 0; cyc < 100 && nres < 3; cyc++) begin
            tick();
            if (busy && !prev_busy && nacc < 3) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc < 3) begin
                    a = va[nacc]; b = vb[nacc]; c_in = vc[nacc];
                end else in_valid = 1'b0;
            end
            prev_busy = busy;
            if (out_valid) begin
                chk_cnt++;
                if ({c_out, sum} !== ve[nres])
                    $display("FAIL b2b_res%0d: got %h want %h", nres, {c_out, sum}, ve[nres]);
                else pass_cnt++;
                nres++;
            end
        end
        in_valid = 1'b0;
        chk_cnt++;
        if (nres !== 3 || nacc !== 3)
            $display("FAIL b2b_count: got acc=%0d res=%0d want 3 3", nacc, nres);
        else pass_cnt++;
        for (int i = 1; i < 3; i++) begin
            chk_cnt++;
            if (i < nacc && acc_cyc[i] - acc_cyc[i-1] !== WIDTH + 2)
                $display("FAIL b2b_gap%0d: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], WIDTH + 2);
            else if (i >= nacc)
                $display("FAIL b2b_gap%0d: got no acceptance want gap %0d", i, WIDTH + 2);
            else pass_cnt++;
        end
        tick();
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int n;
        out_ready = 1'b1;
        sub = 1'b1;
        start(8'h05, 8'h07, 1'b1);
        wait_done(n);
        chk_cnt++;
        if ({c_out, sum} !== 9'h0FE) $display("FAIL sub_5_7: got %h want 0FE", {c_out, sum});
        else pass_cnt++;
        tick();
        start(8'h07, 8'h05, 1'b0);
        wait_done(n);
        chk_cnt++;
        if ({c_out, sum} !== 9'h102) $display("FAIL sub_7_5: got %h want 102", {c_out, sum});
        else pass_cnt++;
        tick();
        sub = 1'b0;
        start(8'h07, 8'h05, 1'b1);
        wait_done(n);
        chk_cnt++;
        if ({c_out, sum} !== 9'h00D) $display("FAIL sub0_add: got %h want 00D", {c_out, sum});
        else pass_cnt++;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        test_reset();
        test_add_basic();
        test_vectors();
        test_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
